cpu_core_param: RTL
===================

# cpu_core_param

Parametrised successor to the fixed 8-bit CPU datapath. Executes one command at a time over a WIDTH-bit operand path with NCH packed data-input channels and a 2*WIDTH-bit accumulator. The accumulator can be fed back as an operand, and a MEM_DEPTH-word data memory supports LOAD and STORE. A valid/ready command handshake replaces the free-running command register, and result, zero and error are registered outputs.

## Interface
- WIDTH, 8: operand width; accumulator, result and memory words are 2*WIDTH.
- NCH, 4: number of data-input channels (≥2). SW = $clog2(NCH+1).
- MEM_DEPTH, 16: memory words; power of 2, ≤ 2^WIDTH. AW = $clog2(MEM_DEPTH).
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cpu_rdy  out  1  command accepted when cmd_valid && cpu_rdy at a clk edge.
- cmd_in  in  4+2*SW  {opcode[3:0], sel_a[SW-1:0], sel_b[SW-1:0]}.
- din  in  NCH*WIDTH  channel k = din[k*WIDTH +: WIDTH].
- result  out  2*WIDTH  accumulator value.
- result_valid  out  1  one-cycle pulse when result, zero and error update.
- zero  out  1  result == 0 after the last command.
- error  out  1  last command was invalid.

## Operation
- Operand select: sel < NCH picks din channel sel. sel == NCH picks acc[WIDTH-1:0]. sel > NCH is invalid.
- Capture: at the accept edge, opcode, A and B are latched into internal registers. din is not sampled again after that edge.
- Opcodes; A and B are zero-extended to 2*WIDTH; all results are 2*WIDTH and wrap modulo 2^(2*WIDTH):
  - 0 ADD: A+B.
  - 1 SUB: A−B, two's complement.
  - 2 MUL: A*B.
  - 3 AND, 4 OR, 5 XOR: bitwise.
  - 6 SHL: A<<B.
  - 7 SHR: A>>B.
  - 8 PASSA: A.
  - 9 LOAD: mem[A[AW-1:0]].
  - 10 STORE: mem[A[AW-1:0]] ← acc; acc unchanged.
  - 11 NOP: acc unchanged.
  - 12–15: invalid.
- Shift amount is the full B value; any shift ≥ 2*WIDTH gives 0.
- Invalid command (invalid opcode or invalid select):
  - acc unchanged, no memory write;
  - error=1, zero=0.
- Valid command: error=0, zero=(new acc == 0).
- Memory: synchronous read and write, contents not reset. Reading an address never written returns an undefined value.
- State machine:
  - IDLE: cpu_rdy=1. On accept, go to EXEC.
  - EXEC: the ALU result is registered, the LOAD read is issued, and the STORE write happens at the EXEC→WB edge. Always goes to WB.
  - WB: acc, zero and error update and result_valid is set at the WB→IDLE edge. Always goes to IDLE.
- cmd_valid while cpu_rdy=0 is ignored. The source must hold cmd_valid and cmd_in until accepted.

## Timing
- Reset values: state IDLE, cpu_rdy=1, result=0, zero=0, error=0, result_valid=0.
- Accept at edge N. cpu_rdy is low during cycles N+1 and N+2. result, zero and error update at edge N+2.
- result_valid is high for exactly the cycle after edge N+2, and cpu_rdy is high in that same cycle.
- Back-to-back: the next command can be accepted at edge N+3, so peak throughput is one command per 3 cycles.
- An accumulator operand accepted at edge N+3 sees the acc value written at edge N+2.
- Reset mid-operation:
  - Reset asserted in EXEC (before the EXEC→WB edge) suppresses the STORE write.
  - Reset asserted in WB discards the update.
  - In both cases outputs return to reset values immediately, without waiting for a clock edge.
- There is no combinational path from cmd_valid or din to any output.

## Configuration
- CPU_CORE_MUL_EN defined: opcode 2 instantiates a WIDTH×WIDTH multiplier; the 2*WIDTH product is exact.
- Undefined: no multiplier is built. Opcode 2 is an invalid command (error=1, acc unchanged).

## Test plan
All scenarios use WIDTH=8, NCH=4, MEM_DEPTH=16.
- Reset: hold reset=0 for 3 cycles with cmd_valid=1 → cpu_rdy=1, result=0, zero=0, error=0, result_valid never pulses. Release reset → the first edge accepts the command.
- ADD: din0=200, din1=100, cmd {0,0,1} accepted at edge N → result=16'd300 and result_valid=1 after edge N+2, zero=0, error=0. cpu_rdy is low exactly 2 cycles. din changes after edge N have no effect.
- SUB and accumulator chaining:
  - din0=5, din1=5, SUB {1,0,1} → result=0, zero=1.
  - Then din2=3, SUB {1,2,1} → 16'hFFFE.
  - Then PASSA {8,4,0} accepted back-to-back at edge N+3 → result=16'hFE (acc low byte).
- MUL: din0=din1=255, {2,0,1} → with macro, result=16'hFE01, error=0. Without macro: error=1, zero=0, result unchanged.
- Memory:
  - ADD 200+100 (acc=300), then STORE with din2=7 {10,2,0}, then NOP, then LOAD {9,2,0} → result=16'd300.
  - Repeat the STORE to address 9 with reset pulsed low during EXEC; after recovery, LOAD address 9 returns its prior value.
- Invalid: sel_a=5 {0,5,1}, then opcode 15 → each gives error=1, zero=0, result unchanged, no memory write. A following valid ADD clears error to 0.

Source files
------------

// File: rtl/cpu_core_param.sv
// Parametrised 3-cycle CPU datapath (IDLE/EXEC/WB) with accumulator, packed din channels and data memory.
// cpu_rdy low for two cycles after each accept; optional multiplier enabled by CPU_CORE_MUL_EN.
module cpu_core_param #(
  parameter int WIDTH     = 8,
  parameter int NCH       = 4,
  parameter int MEM_DEPTH = 16,
  localparam int SW = $clog2(NCH + 1),
  localparam int AW = $clog2(MEM_DEPTH),
  localparam int DW = 2 * WIDTH,
  localparam int CW = 4 + 2 * SW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cpu_rdy,
  input  logic [CW-1:0]        cmd_in,
  input  logic [NCH*WIDTH-1:0] din,
  output logic [DW-1:0]        result,
  output logic                 result_valid,
  output logic                 zero,
  output logic                 error
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_MUL   = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_SHL   = 4'd6;
  localparam logic [3:0] OP_SHR   = 4'd7;
  localparam logic [3:0] OP_PASSA = 4'd8;
  localparam logic [3:0] OP_LOAD  = 4'd9;
  localparam logic [3:0] OP_STORE = 4'd10;
  localparam logic [3:0] OP_NOP   = 4'd11;

  localparam logic [SW-1:0] ACC_SEL   = SW'(NCH);
  localparam logic [DW-1:0] SHIFT_LIM = DW'(DW);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_e;

  state_e state_q, state_d;

  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             bad_q, bad_d;
  logic [DW-1:0]    alu_q, alu_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic             zero_q, zero_d;
  logic             error_q, error_d;
  logic             rv_q, rv_d;
  logic [DW-1:0]    rd_q;

  logic [DW-1:0]    mem [MEM_DEPTH];

  logic             accept;
  logic             mem_we;
  logic             mem_re;
  logic [3:0]       cmd_op;
  logic [SW-1:0]    cmd_sa;
  logic [SW-1:0]    cmd_sb;
  logic             cmd_bad;
  logic [DW-1:0]    a_ext;
  logic [DW-1:0]    b_ext;
  logic [DW-1:0]    alu_res;
  logic [DW-1:0]    wb_val;

  assign {cmd_op, cmd_sa, cmd_sb} = cmd_in;

  // Selects a din channel, or the accumulator low word when sel == NCH.
  function automatic logic [WIDTH-1:0] pick_operand(input logic [SW-1:0]        sel,
                                                    input logic [NCH*WIDTH-1:0] d,
                                                    input logic [WIDTH-1:0]     acc_lo);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int k = 0; k < NCH; k++) begin
      if (sel == SW'(k)) v = d[k*WIDTH +: WIDTH];
    end
    if (sel == ACC_SEL) v = acc_lo;
    return v;
  endfunction

  always_comb begin
    cmd_bad = (cmd_sa > ACC_SEL) || (cmd_sb > ACC_SEL) || (cmd_op > OP_NOP);
`ifndef CPU_CORE_MUL_EN
    if (cmd_op == OP_MUL) cmd_bad = 1'b1;
`endif
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_valid) state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    cpu_rdy = 1'b0;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    case (state_q)
      S_IDLE: cpu_rdy = 1'b1;
      S_EXEC: begin
        mem_we = (op_q == OP_STORE) && !bad_q;
        mem_re = (op_q == OP_LOAD) && !bad_q;
      end
      default: ;
    endcase
  end

  assign accept = cmd_valid && cpu_rdy;

  always_comb begin
    a_ext   = DW'(a_q);
    b_ext   = DW'(b_q);
    alu_res = '0;
    case (op_q)
      OP_ADD:   alu_res = a_ext + b_ext;
      OP_SUB:   alu_res = a_ext - b_ext;
`ifdef CPU_CORE_MUL_EN
      OP_MUL:   alu_res = a_ext * b_ext;
`endif
      OP_AND:   alu_res = a_ext & b_ext;
      OP_OR:    alu_res = a_ext | b_ext;
      OP_XOR:   alu_res = a_ext ^ b_ext;
      OP_SHL:   alu_res = (b_ext >= SHIFT_LIM) ? '0 : (a_ext << b_q);
      OP_SHR:   alu_res = (b_ext >= SHIFT_LIM) ? '0 : (a_ext >> b_q);
      OP_PASSA: alu_res = a_ext;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    case (op_q)
      OP_LOAD:         wb_val = rd_q;
      OP_STORE, OP_NOP: wb_val = acc_q;
      default:         wb_val = alu_q;
    endcase
  end

  always_comb begin
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    bad_d   = bad_q;
    alu_d   = alu_q;
    acc_d   = acc_q;
    zero_d  = zero_q;
    error_d = error_q;
    rv_d    = 1'b0;
    if (accept) begin
      op_d  = cmd_op;
      a_d   = pick_operand(cmd_sa, din, acc_q[WIDTH-1:0]);
      b_d   = pick_operand(cmd_sb, din, acc_q[WIDTH-1:0]);
      bad_d = cmd_bad;
    end
    if (state_q == S_EXEC) alu_d = alu_res;
    if (state_q == S_WB) begin
      rv_d = 1'b1;
      if (bad_q) begin
        error_d = 1'b1;
        zero_d  = 1'b0;
      end else begin
        acc_d   = wb_val;
        error_d = 1'b0;
        zero_d  = (wb_val == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      bad_q   <= 1'b0;
      alu_q   <= '0;
      acc_q   <= '0;
      zero_q  <= 1'b0;
      error_q <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      bad_q   <= bad_d;
      alu_q   <= alu_d;
      acc_q   <= acc_d;
      zero_q  <= zero_d;
      error_q <= error_d;
      rv_q    <= rv_d;
    end
  end

  // Memory is not reset; a reset during EXEC leaves state_q out of EXEC, so no write occurs.
  always_ff @(posedge clk) begin
    if (mem_we) mem[a_q[AW-1:0]] <= acc_q;
    if (mem_re) rd_q <= mem[a_q[AW-1:0]];
  end

  assign result       = acc_q;
  assign result_valid = rv_q;
  assign zero         = zero_q;
  assign error        = error_q;

endmodule
